// File: rtl/cnt_chain_ctrl.sv
// Run/stop/step/load sequencer for the counter chain: debounced buttons, short/long press events, control FSM.
// Optional display auto-scan of the digit pointer is compiled in with `define CNT_CTRL_AUTOSCAN_EN.
module cnt_chain_ctrl #(
    parameter int DEBOUNCE_MS = 10,
    parameter int LONG_MS     = 1000,
    parameter int SCAN_MS     = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce1ms,
    input  logic       tick_in,
    input  logic       btn_run,
    input  logic       btn_step,
    input  logic [1:0] ptr_sel,
    output logic       ce_out,
    output logic       load,
    output logic       clr,
    output logic [1:0] state,
    output logic [1:0] ptr
);

    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW = $clog2(LONG_MS + 1);
    localparam int BTN_RUN  = 0;
    localparam int BTN_STEP = 1;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_LOAD = 2'd3
    } state_t;

    logic [1:0] btn_s;
    logic [1:0] short_s;
    logic [1:0] long_s;

    assign btn_s = {btn_step, btn_run};

    for (genvar b = 0; b < 2; b++) begin : g_btn
        logic          sync1_r;
        logic          sync2_r;
        logic          deb_r;
        logic          deb_d_r;
        logic [DW-1:0] deb_cnt_r;
        logic [HW-1:0] hold_r;
        logic          short_r;
        logic          long_r;

        // Two-flop synchronizer for the raw button level
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync1_r <= 1'b0;
                sync2_r <= 1'b0;
            end else begin
                sync1_r <= btn_s[b];
                sync2_r <= sync1_r;
            end
        end

        // Debouncer: level must disagree for DEBOUNCE_MS consecutive ms samples to flip
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                deb_r     <= 1'b0;
                deb_cnt_r <= '0;
            end else if (ce1ms) begin
                if (sync2_r != deb_r) begin
                    if (deb_cnt_r >= DW'(DEBOUNCE_MS - 1)) begin
                        deb_r     <= sync2_r;
                        deb_cnt_r <= '0;
                    end else begin
                        deb_cnt_r <= deb_cnt_r + DW'(1);
                    end
                end else begin
                    deb_cnt_r <= '0;
                end
            end
        end

        // Hold timer and press classification; the saturated count suppresses both a second long and a short
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                deb_d_r <= 1'b0;
                hold_r  <= '0;
                short_r <= 1'b0;
                long_r  <= 1'b0;
            end else begin
                deb_d_r <= deb_r;
                if (!deb_r) begin
                    hold_r <= '0;
                end else if (ce1ms && (hold_r < HW'(LONG_MS))) begin
                    hold_r <= hold_r + HW'(1);
                end
                long_r  <= ce1ms & deb_r & (hold_r == HW'(LONG_MS - 1));
                short_r <= deb_d_r & ~deb_r & (hold_r < HW'(LONG_MS));
            end
        end

        assign short_s[b] = short_r;
        assign long_s[b]  = long_r;
    end

    state_t state_r;
    state_t state_next_s;
    logic   clr_next_s;
    logic   load_r;
    logic   clr_r;

    // Next-state decode; run events are tested before step events so they win on a tie
    always_comb begin
        state_next_s = state_r;
        clr_next_s   = 1'b0;
        case (state_r)
            ST_STOP: begin
                if (short_s[BTN_RUN]) begin
                    state_next_s = ST_RUN;
                end else if (long_s[BTN_RUN]) begin
                    state_next_s = ST_LOAD;
                end else if (short_s[BTN_STEP]) begin
                    state_next_s = ST_STEP;
                end else if (long_s[BTN_STEP]) begin
                    clr_next_s = 1'b1;
                end else begin
                    state_next_s = ST_STOP;
                end
            end
            ST_RUN: begin
                if (short_s[BTN_RUN]) begin
                    state_next_s = ST_STOP;
                end else if (long_s[BTN_RUN]) begin
                    state_next_s = ST_LOAD;
                end else if (long_s[BTN_STEP]) begin
                    state_next_s = ST_STOP;
                    clr_next_s   = 1'b1;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_STEP: state_next_s = ST_STOP;
            ST_LOAD: state_next_s = ST_STOP;
            default: state_next_s = ST_STOP;
        endcase
    end

    // State register with strobes aligned to the first cycle of the new state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_STOP;
            load_r  <= 1'b0;
            clr_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            load_r  <= (state_next_s == ST_LOAD);
            clr_r   <= clr_next_s;
        end
    end

    // Count-enable must pass tick_in with no latency, so it is decoded from the registered state
    assign ce_out = ((state_r == ST_RUN) & tick_in) | (state_r == ST_STEP);
    assign load   = load_r;
    assign clr    = clr_r;
    assign state  = state_r;

    logic [1:0] ptr_r;

`ifdef CNT_CTRL_AUTOSCAN_EN
    localparam int SW = $clog2(SCAN_MS + 1);
    logic [SW-1:0] scan_cnt_r;
    logic          unused_ptr_sel_s;

    assign unused_ptr_sel_s = ^ptr_sel;

    // Auto-scan: advance the digit pointer every SCAN_MS ms
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt_r <= '0;
            ptr_r      <= 2'd0;
        end else if (ce1ms) begin
            if (scan_cnt_r >= SW'(SCAN_MS - 1)) begin
                scan_cnt_r <= '0;
                ptr_r      <= ptr_r + 2'd1;
            end else begin
                scan_cnt_r <= scan_cnt_r + SW'(1);
            end
        end
    end
`else
    // Manual pointer, registered once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= 2'd0;
        end else begin
            ptr_r <= ptr_sel;
        end
    end
`endif

    assign ptr = ptr_r;

endmodule

// File: doc/cnt_chain_ctrl.md
# cnt_chain_ctrl

Run/stop/step/load sequencer for the four-stage counter chain on the seven-segment board. It debounces two pushbuttons on the 1 ms tick and classifies each press as short or long. A four-state FSM uses these press events to gate the chain's count-enable, issue single steps, and pulse the load and clear strobes. It also drives the display digit pointer. It sits between the tick generator, the counter chain and the display driver.

## Interface
Parameters:
- DEBOUNCE_MS, 10: consecutive 1 ms samples a button level must hold before the debounced level changes.
- LONG_MS, 1000: debounced hold time, in ms, that classifies a press as long.
- SCAN_MS, 1000: display pointer dwell, in ms, when auto-scan is compiled in.

Ports:
- clk  input  1  system clock; only clock.
- rst  input  1  reset, asynchronous, active-high.
- ce1ms  input  1  one-cycle pulse every 1 ms.
- tick_in  input  1  count-enable pulse from the tick generator.
- btn_run  input  1  raw run/stop button, active-high, asynchronous.
- btn_step  input  1  raw step button, active-high, asynchronous.
- ptr_sel  input  2  manual digit pointer; used only without auto-scan.
- ce_out  output  1  gated count-enable to the chain's first stage.
- load  output  1  one-cycle load strobe to the loadable stage.
- clr  output  1  one-cycle clear strobe to all stages.
- state  output  2  FSM state: 0 STOP, 1 RUN, 2 STEP, 3 LOAD.
- ptr  output  2  digit pointer to the display driver.

## Operation
- Each button passes through a 2-flop synchronizer, then a debouncer clocked by ce1ms.
- Debouncer: a counter runs while the synchronized level differs from the debounced level. It clears on agreement and flips the debounced level on reaching DEBOUNCE_MS.
- Hold counter: counts ce1ms while the debounced level is high and saturates at LONG_MS.
- Long event: one-cycle pulse when the hold counter reaches LONG_MS. At most one per hold.
- Short event: one-cycle pulse on the debounced falling edge when the hold counter is below LONG_MS.
- Event names: run_s, run_l (btn_run short/long); step_s, step_l (btn_step short/long).
- STOP: ce_out=0.
  - run_s -> RUN.
  - run_l -> LOAD.
  - step_s -> STEP.
  - step_l -> clr pulse, stay in STOP.
- RUN: ce_out=tick_in (combinational AND).
  - run_s -> STOP.
  - run_l -> LOAD.
  - step_l -> clr pulse, go to STOP.
  - step_s ignored.
- STEP: ce_out=1 for exactly one cycle, then -> STOP.
- LOAD: load=1 for exactly one cycle, ce_out=0, then -> STOP.
- Simultaneous events: run_* beats step_*. Events arriving while in STEP or LOAD are dropped.
- Reset mid-operation: all counters, synchronizers and the FSM clear immediately. No strobe is emitted.

## Timing
- Reset values:
  - state=STOP, ce_out=0, load=0, clr=0, ptr=0.
  - Debounced levels=0, all counters=0.
- Press latency:
  - Raw edge to debounced edge: 2 clk, plus up to DEBOUNCE_MS ms, plus 1 ms.
  - Event is registered; the FSM transitions on the clk after the event.
- Registered outputs: load, clr and state are registered, so the strobes are high on the first cycle in the new state.
- ce_out timing:
  - In RUN, ce_out follows tick_in with 0 latency.
  - The tick_in coincident with the RUN->STOP transition cycle is still passed through.
- Width rules:
  - Debounce counter width is $clog2(DEBOUNCE_MS+1).
  - Hold counter width is $clog2(LONG_MS+1).
  - Both saturate and never wrap.

## Configuration
- CNT_CTRL_AUTOSCAN_EN defined:
  - A ms counter advances ptr 0→1→2→3→0 every SCAN_MS ce1ms pulses, in all states.
  - ptr_sel is ignored.
- CNT_CTRL_AUTOSCAN_EN undefined:
  - ptr is ptr_sel registered once, giving 1-cycle latency.
  - The scan counter is not built.

## Test plan
- Reset, then btn_run held 5 ms (DEBOUNCE_MS=2, LONG_MS=20) -> one run_s, state 0→1. ce_out mirrors a 1-per-10-cycle tick_in.
- btn_run bouncing 1 ms high / 1 ms low for 10 ms with DEBOUNCE_MS=2 -> no event, state unchanged.
- In RUN, btn_run held 25 ms -> one run_l at 20 ms, state 1→3→0. load high exactly 1 cycle, no second long event before release.
- In STOP, three short btn_step presses -> three STEP visits, exactly three 1-cycle ce_out pulses.
- btn_run and btn_step short releases on the same ce1ms -> only run_s acted on: STOP→RUN, no ce_out step pulse.
- CNT_CTRL_AUTOSCAN_EN defined, SCAN_MS=3 -> ptr 0,1,2,3,0 at 3 ms intervals. rst asserted mid-count -> ptr=0 and state=STOP immediately.
